// File: rtl/instr_sequencer.sv
// Instruction issue front end: buffers instructions and holds each on inn for four run steps.
// Push to visible on inn takes two edges. in_ready drops when the FIFO is full or during clear.
module instr_sequencer #(
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  input  logic                     run,
  input  logic                     clear,
  output logic [INSTR_W-1:0]       inn,
  output logic [1:0]               counter,
  output logic                     busy,
  output logic                     done,
  output logic                     err_illegal,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t               state_q, state_d;
  logic [1:0]           counter_q, counter_d;
  logic [INSTR_W-1:0]   inn_q, inn_d;
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic [INSTR_W-1:0]   mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;

  logic [2:0] opcode;
  logic       legal;
  logic       push;
  logic       wr_en;
  logic       pop;

  assign opcode   = in_instr[INSTR_W-1 -: 3];
  // Opcodes 011 and 110 are not decoded by the control unit.
  assign legal    = (opcode != 3'b011) && (opcode != 3'b110);
  assign in_ready = !clear && (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wr_en    = push && legal;

  assign done = (state_q == EXEC) && run && (counter_q == 2'd3) && !clear && !reset;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    inn_d     = inn_q;
    pop       = 1'b0;
    mem_d     = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = in_instr;

    case (state_q)
      IDLE: begin
        if (run && (count_q != '0)) begin
          pop       = 1'b1;
          inn_d     = mem_q[rd_ptr_q];
          counter_d = 2'd0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (run) begin
          if (counter_q == 2'd3) begin
            counter_d = 2'd0;
            if (count_q != '0) begin
              pop   = 1'b1;
              inn_d = mem_q[rd_ptr_q];
            end else begin
              state_d = IDLE;
            end
          end else begin
            counter_d = counter_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = push && !legal;

    // Abort: flush the queue, drop any in-flight instruction, keep inn.
    if (clear) begin
      state_d   = IDLE;
      counter_d = 2'd0;
      inn_d     = inn_q;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= 2'd0;
      inn_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      inn_q     <= inn_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign inn         = inn_q;
  assign counter     = counter_q;
  assign busy        = (state_q == EXEC);
  assign err_illegal = err_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: queue-based reference model plus directed literal checks.
module tb_instr_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_instr = '0;
  logic       in_ready;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic [8:0] inn;
  logic [1:0] counter;
  logic       busy;
  logic       done;
  logic       err_illegal;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  instr_sequencer #(.INSTR_W(9), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .run(run), .clear(clear), .inn(inn),
    .counter(counter), .busy(busy), .done(done),
    .err_illegal(err_illegal), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending words plus the instruction in flight.
  logic [8:0] m_q[$];
  logic [8:0] m_inn = '0;
  int         m_step = 0;
  bit         m_busy = 1'b0;
  bit         m_err = 1'b0;
  bit         m_acc, m_ill;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_inn = '0; m_step = 0; m_busy = 1'b0; m_err = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_step = 0; m_busy = 1'b0; m_err = 1'b0;
    end else begin
      m_acc = in_valid && (m_q.size() < DEPTH);
      m_ill = (in_instr[8:6] == 3'd3) || (in_instr[8:6] == 3'd6);
      if (run && (!m_busy || m_step == 3)) begin
        if (m_q.size() > 0) begin
          m_inn = m_q.pop_front();
          m_step = 0;
          m_busy = 1'b1;
        end else if (m_busy) begin
          m_busy = 1'b0;
          m_step = 0;
        end
      end else if (run && m_busy) begin
        m_step++;
      end
      if (m_acc && !m_ill) m_q.push_back(in_instr);
      m_err = m_acc && m_ill;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", in_ready, (!clear && m_q.size() < DEPTH) ? 1 : 0);
      chk("m_done", done, (m_busy && run && m_step == 3 && !clear && !reset) ? 1 : 0);
      chk("m_inn", inn, m_inn);
      chk("m_counter", counter, m_step);
      chk("m_busy", busy, m_busy);
      chk("m_fifo_count", fifo_count, m_q.size());
      chk("m_err", err_illegal, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] words [4];

  initial begin
    words[0] = 9'h00A; words[1] = 9'h04B; words[2] = 9'h08C; words[3] = 9'h111;

    // Reset held two cycles with a word offered.
    reset = 1'b1; in_valid = 1'b1; in_instr = 9'h00A;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_inn", inn, 0);
    chk("rst_counter", counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo", fifo_count, 0);
    chk("rst_ready", in_ready, 1);

    // Single issue.
    run = 1'b1; in_valid = 1'b1; in_instr = 9'b000_001_010;
    tick();
    in_valid = 1'b0;
    chk("single_fifo1", fifo_count, 1);
    chk("single_nobypass", busy, 0);
    tick();
    chk("single_inn", inn, 9'h00A);
    chk("single_cnt0", counter, 0);
    tick(); chk("single_cnt1", counter, 1);
    tick(); chk("single_cnt2", counter, 2);
    chk("single_done_early", done, 0);
    tick(); chk("single_cnt3", counter, 3);
    chk("single_done", done, 1);
    tick(); chk("single_idle", busy, 0);
    chk("single_inn_kept", inn, 9'h00A);

    // Fill to full with run low, then drain back to back.
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
    end
    in_instr = 9'h1C5;
    #1;
    chk("full_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    tick();
    in_valid = 1'b0;
    chk("full_count_hold", fifo_count, 4);
    run = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("b2b_counter", counter, i % 4);
      chk("b2b_done", done, (i % 4 == 3) ? 1 : 0);
      chk("b2b_inn", inn, words[i / 4]);
      chk("b2b_busy", busy, 1);
      tick();
    end
    chk("b2b_idle", busy, 0);
    chk("b2b_empty", fifo_count, 0);

    // Illegal opcodes.
    in_valid = 1'b1; in_instr = 9'b011_000_001;
    #1; chk("ill_ready", in_ready, 1);
    tick();
    chk("ill_err1", err_illegal, 1);
    chk("ill_fifo1", fifo_count, 0);
    in_instr = 9'b110_111_111;
    tick();
    in_valid = 1'b0;
    chk("ill_err2", err_illegal, 1);
    chk("ill_fifo2", fifo_count, 0);
    tick();
    chk("ill_err_clr", err_illegal, 0);
    chk("ill_noissue", busy, 0);

    // Run stall at counter 2.
    in_valid = 1'b1; in_instr = 9'h04B;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("stall_at2", counter, 2);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", counter, 2);
      chk("stall_nodone", done, 0);
    end
    run = 1'b1;
    tick();
    chk("stall_resume", counter, 3);
    chk("stall_done", done, 1);
    tick();
    chk("stall_idle", busy, 0);

    // Clear mid-operation.
    run = 1'b0;
    for (int i = 1; i < 4; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
    end
    in_valid = 1'b0; run = 1'b1;
    tick(); tick();
    chk("clr_pre_cnt", counter, 1);
    chk("clr_pre_fifo", fifo_count, 2);
    clear = 1'b1; in_valid = 1'b1; in_instr = 9'h00A;
    #1;
    chk("clr_ready", in_ready, 0);
    chk("clr_nodone", done, 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_counter", counter, 0);
    chk("clr_fifo", fifo_count, 0);
    chk("clr_err", err_illegal, 0);
    chk("clr_inn_kept", inn, 9'h04B);
    tick();
    chk("clr_stays_idle", busy, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      run      = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1);
      in_instr = 9'($urandom_range(0, 511));
      tick();
    end
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction issue front end for the 16-bit processor datapath. Accepts 9-bit instructions (opcode[8:6], rX[5:3], rY[2:0]) over a valid/ready handshake and buffers them in a small FIFO. Presents each instruction on inn, held stable for exactly four steps, while driving the 2-bit step counter consumed by the control unit. Handles the clear/abort request and rejects opcodes the control unit does not decode.

Parameters:
INSTR_W, 9, instruction width (opcode 3 + two 3-bit register fields)
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  producer has an instruction on in_instr
in_instr  in  INSTR_W  instruction word
in_ready  out  1  sequencer can accept; combinational = !clear && (count < DEPTH)
run  in  1  step enable; 0 freezes counter and issue
clear  in  1  synchronous abort + flush
inn  out  INSTR_W  current instruction to control unit (registered)
counter  out  2  step 0..3 to control unit (registered)
busy  out  1  1 while state = EXEC
done  out  1  1-cycle pulse, last step of an instruction
err_illegal  out  1  registered 1-cycle pulse, illegal opcode dropped
fifo_count  out  clog2(DEPTH)+1  entries currently buffered

Behaviour:
- Reset (clk edge with reset=1): state IDLE, counter=0, inn=0, FIFO empty (rd/wr pointers 0, count 0), err_illegal=0. busy=0, done=0, in_ready=1 once reset deasserts. Reset overrides clear, push, pop.
- Priority per edge: reset > clear > normal operation.
- Push: accept when in_valid && in_ready. Legal opcodes: 000,001,010,100,101,111. Opcodes 011 and 110: handshake completes, word NOT written, err_illegal=1 on the following cycle only. Legal word written at wr_ptr; pointers wrap modulo DEPTH.
- Full: in_ready=0 when count=DEPTH, even if a pop occurs in the same cycle (no full-bypass).
- No empty bypass: a word pushed at edge k is first visible on inn, with counter=0, after edge k+1 at the earliest.
- Same-edge push and pop: count unchanged, both pointers advance.
- FSM, IDLE: counter=0, inn holds last value. If run && count>0: pop head into inn, counter<=0, go EXEC.
- FSM, EXEC, run=0: counter, inn and FIFO head frozen. done=0. Pushes still accepted.
- FSM, EXEC, run=1, counter<3: counter<=counter+1.
- done: combinational = EXEC && run && counter==3.
- FSM, EXEC, run=1, counter==3: if count>0, pop next into inn, counter<=0, stay EXEC (back-to-back, no bubble). Otherwise counter<=0, go IDLE, inn retained.
- Any instruction occupies exactly 4 consecutive run=1 cycles in EXEC. Throughput is one instruction per 4 cycles.
- Clear: next state IDLE, counter<=0, FIFO flushed (count 0, pointers 0). inn retained. No done pulse that cycle. in_ready=0 during clear; in_valid ignored. err_illegal not raised for words presented during clear.
- Reset or clear mid-instruction: the instruction is aborted and never completes; no partial done.
- fifo_count: registered, reflects state after each edge.

Test Plan:
- Reset/defaults: hold reset 2 cycles with in_valid=1 -> inn=0, counter=0, busy=0, fifo_count=0, in_ready=1 after release, no push recorded.
- Single issue: push 9'b000_001_010 at edge k, run=1 -> after k+1 inn=0x00A, counter=0. Counter then 1,2,3. done=1 exactly at counter=3. Returns to IDLE, busy=0.
- Back-to-back and full: push 0x00A, 0x04B, 0x08C, 0x111, then a 5th word with run=0 -> in_ready=0 at fifo_count=4, 5th word not accepted. Release run -> four instructions issue with counter 0,1,2,3 repeating and no bubble. 4 done pulses.
- Illegal opcode: push 9'b011_000_001, then 9'b110_111_111 -> both handshakes complete, fifo_count stays 0, err_illegal pulses once per word, nothing issued.
- Run stall: during EXEC at counter=2 drop run for 3 cycles -> counter stays 2, done=0. Resume -> 3 with done=1.
- Clear mid-operation: 3 entries queued, executing at counter=1, pulse clear with in_valid=1 -> next cycle IDLE, counter=0, fifo_count=0, no done, in_ready=0 during clear, pushed word discarded.
